// File: rtl/dsram_axi_slave_pkg.sv
// Shared widths, response codes and FSM encoding
// for the single-beat AXI-style data SRAM slave.
package dsram_axi_slave_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 8;
  localparam int RESP_W = 2;
  localparam int LANES  = 4;
  localparam int CNT_W  = 4;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_RESP,
    WR_WAIT,
    WR_RESP
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [LANES-1:0]  strb;
  } wbeat_t;

endpackage

// File: rtl/dsram_axi_slave_if.sv
// Read/write channel bundle between a requester
// and the data SRAM slave.
interface dsram_axi_slave_if;
  import dsram_axi_slave_pkg::*;

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [RESP_W-1:0] rresp;

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;

  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;

  logic              bvalid;
  logic              bready;
  logic [RESP_W-1:0] bresp;

  modport slave (
    input  arvalid, araddr, rready,
    input  awvalid, awaddr,
    input  wvalid, wdata, wstrb, bready,
    output arready, rvalid, rdata, rresp,
    output awready, wready, bvalid, bresp
  );

  modport master (
    output arvalid, araddr, rready,
    output awvalid, awaddr,
    output wvalid, wdata, wstrb, bready,
    input  arready, rvalid, rdata, rresp,
    input  awready, wready, bvalid, bresp
  );

endinterface

// File: rtl/dsram_bank.sv
// Byte-lane write-enabled word array with a
// registered read port; contents are never reset.
module dsram_bank
  import dsram_axi_slave_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IW    = 10
) (
  input  logic              clk,
  input  logic [LANES-1:0]  we,
  input  logic              re,
  input  logic [IW-1:0]     idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we[i]) begin
        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dsram_axi_slave.sv
// Single-outstanding data SRAM slave: accept,
// fixed-latency wait, then hold response.
module dsram_axi_slave
  import dsram_axi_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          RD_LAT      = 2,
  parameter int          WR_LAT      = 2
) (
  input  logic           clk,
  input  logic           rst,
  dsram_axi_slave_if.slave bus
);

  localparam int IW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [33:0] LO = {2'b00, BASE_ADDR};
  localparam logic [33:0] HI =
    LO + 34'(DEPTH_WORDS) * 34'd4;

  localparam logic [CNT_W-1:0] RD_LD =
    CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LD =
    CNT_W'(WR_LAT - 1);

  state_t            state;
  state_t            state_n;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_n;
  logic [IW-1:0]     idx_q;
  logic              err_q;
  wbeat_t            wb_q;
  logic              rdy_q;

  logic              idle;
  logic              wr_go;
  logic              rd_go;
  logic [ADDR_W-1:0] acc_addr;
  logic [ADDR_W-1:0] rel;
  logic              in_rng;
  logic              rd_en;
  logic              wr_en;
  logic [LANES-1:0]  bank_we;
  logic [DATA_W-1:0] bank_q;
  logic              unused_bits;

  assign idle  = rdy_q && (state == IDLE);
  assign wr_go = idle && bus.awvalid
              && bus.wvalid;
  assign rd_go = idle && bus.arvalid && !wr_go;

  assign acc_addr = wr_go ? bus.awaddr
                          : bus.araddr;
  assign rel      = acc_addr - BASE_ADDR;
  assign in_rng   = ({2'b00, acc_addr} >= LO)
                 && ({2'b00, acc_addr} < HI);

  assign unused_bits =
    ^{rel[1:0], rel[ADDR_W-1:IW+2],
      bus.wstrb[STRB_W-1:LANES]};

  // arready is withheld while a write is being
  // taken so a requester never sees a false accept
  assign bus.arready =
    idle && !(bus.awvalid && bus.wvalid);
  assign bus.awready = idle;
  assign bus.wready  = idle;

  assign bus.rvalid = (state == RD_RESP);
  assign bus.bvalid = (state == WR_RESP);

  assign bus.rdata =
    (bus.rvalid && !err_q) ? bank_q : '0;
  assign bus.rresp =
    (bus.rvalid && err_q) ? RESP_SLVERR
                          : RESP_OKAY;
  assign bus.bresp =
    (bus.bvalid && err_q) ? RESP_SLVERR
                          : RESP_OKAY;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    unique case (state)
      IDLE: begin
        if (wr_go) begin
          state_n = WR_WAIT;
          cnt_n   = WR_LD;
        end else if (rd_go) begin
          state_n = RD_WAIT;
          cnt_n   = RD_LD;
        end
      end
      RD_WAIT: begin
        if (cnt == '0) begin
          state_n = RD_RESP;
          rd_en   = !err_q;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      RD_RESP: begin
        if (bus.rready) state_n = IDLE;
      end
      WR_WAIT: begin
        if (cnt == '0) begin
          state_n = WR_RESP;
          wr_en   = !err_q;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      WR_RESP: begin
        if (bus.bready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      rdy_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      rdy_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= '0;
      err_q <= 1'b0;
      wb_q  <= '0;
    end else if (wr_go || rd_go) begin
      idx_q <= rel[IW+1:2];
      err_q <= !in_rng;
      if (wr_go) begin
        wb_q.data <= bus.wdata;
        wb_q.strb <= bus.wstrb[LANES-1:0];
      end
    end
  end

  assign bank_we = wr_en ? wb_q.strb : '0;

  dsram_bank #(
    .DEPTH (DEPTH_WORDS),
    .IW    (IW)
  ) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .re    (rd_en),
    .idx   (idx_q),
    .wdata (wb_q.data),
    .rdata (bank_q)
  );

endmodule

// File: tb/tb_dsram_axi_slave.sv
// Table-driven and scenario bench for
// dsram_axi_slave with a response scoreboard.
module tb_dsram_axi_slave;

  localparam int RD_LAT = 2;
  localparam int WR_LAT = 2;
  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ERR = 2'b10;

  logic clk;
  logic rst;

  dsram_axi_slave_if bus();

  dsram_axi_slave #(
    .BASE_ADDR   (32'h8000_0000),
    .DEPTH_WORDS (1024),
    .RD_LAT      (RD_LAT),
    .WR_LAT      (WR_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  strb;
    logic [31:0] exp;
    logic [1:0]  resp;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_chk;
  int   n_pass;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic tmo(input string nm);
    n_chk++;
    $display("FAIL %s actual=timeout required=handshake",
             nm);
  endtask

  task automatic wait_acc(input logic is_wr,
                          input string nm);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (is_wr ? (bus.awready && bus.wready)
                : bus.arready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) tmo(nm);
  endtask

  task automatic wait_rsp(input logic is_wr,
                          output int lat);
    int k;
    k = 1;
    while (!(is_wr ? bus.bvalid : bus.rvalid)
           && k < 40) begin
      @(negedge clk);
      k++;
    end
    lat = k - 1;
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [7:0]  s,
                    input logic [1:0]  er);
    int   lat;
    exp_t e;
    sb.push_back('{32'h0, er});
    bus.awvalid = 1'b1;
    bus.awaddr  = a;
    bus.wvalid  = 1'b1;
    bus.wdata   = d;
    bus.wstrb   = s;
    wait_acc(1'b1, "wr_accept");
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b1;
    wait_rsp(1'b1, lat);
    if (!bus.bvalid) tmo("wr_bvalid");
    chk("wr_latency", 32'(lat), 32'(WR_LAT));
    e = sb.pop_front();
    chk("bresp", 32'(bus.bresp), 32'(e.resp));
    @(negedge clk);
    chk("bvalid_drop", 32'(bus.bvalid), 32'h0);
    bus.bready = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a,
                    input logic [31:0] x,
                    input logic [1:0]  er);
    int   lat;
    exp_t e;
    sb.push_back('{x, er});
    bus.arvalid = 1'b1;
    bus.araddr  = a;
    wait_acc(1'b0, "rd_accept");
    @(negedge clk);
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    wait_rsp(1'b0, lat);
    if (!bus.rvalid) tmo("rd_rvalid");
    chk("rd_latency", 32'(lat), 32'(RD_LAT));
    e = sb.pop_front();
    chk("rdata", bus.rdata, e.data);
    chk("rresp", 32'(bus.rresp), 32'(e.resp));
    @(negedge clk);
    chk("rvalid_drop", 32'(bus.rvalid), 32'h0);
    bus.rready = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [31:0] held;
    n_chk  = 0;
    n_pass = 0;
    rst = 1'b0;
    bus.arvalid = 1'b0;
    bus.araddr  = '0;
    bus.rready  = 1'b0;
    bus.awvalid = 1'b0;
    bus.awaddr  = '0;
    bus.wvalid  = 1'b0;
    bus.wdata   = '0;
    bus.wstrb   = '0;
    bus.bready  = 1'b0;

    tbl.push_back({1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 32'h0, OK});
    tbl.push_back({1'b0, 32'h8000_0012, 32'h0, 8'h00, 32'hDEAD_BEEF, OK});
    tbl.push_back({1'b1, 32'h8000_0010, 32'h1122_3344, 8'h0F, 32'h0, OK});
    tbl.push_back({1'b1, 32'h8000_0010, 32'hAA00_0000, 8'h08, 32'h0, OK});
    tbl.push_back({1'b0, 32'h8000_0010, 32'h0, 8'h00, 32'hAA22_3344, OK});
    tbl.push_back({1'b1, 32'h8000_0014, 32'hCAFE_F00D, 8'h0F, 32'h0, OK});
    tbl.push_back({1'b1, 32'h8000_0014, 32'h5566_7788, 8'hF0, 32'h0, OK});
    tbl.push_back({1'b0, 32'h8000_0014, 32'h0, 8'h00, 32'hCAFE_F00D, OK});
    tbl.push_back({1'b1, 32'h8000_0014, 32'h0102_0304, 8'h00, 32'h0, OK});
    tbl.push_back({1'b0, 32'h8000_0014, 32'h0, 8'h00, 32'hCAFE_F00D, OK});
    tbl.push_back({1'b1, 32'h8000_0014, 32'h00AB_0000, 8'h04, 32'h0, OK});
    tbl.push_back({1'b0, 32'h8000_0014, 32'h0, 8'h00, 32'hCAAB_F00D, OK});
    tbl.push_back({1'b1, 32'h8000_0000, 32'h0BAD_C0DE, 8'h0F, 32'h0, OK});
    tbl.push_back({1'b1, 32'h8000_0FFC, 32'hFFFF_FFFF, 8'h0F, 32'h0, OK});
    tbl.push_back({1'b0, 32'h8000_0FFF, 32'h0, 8'h00, 32'hFFFF_FFFF, OK});
    tbl.push_back({1'b0, 32'h8000_1000, 32'h0, 8'h00, 32'h0, ERR});
    tbl.push_back({1'b1, 32'h7FFF_FFFC, 32'h1234_5678, 8'h0F, 32'h0, ERR});
    tbl.push_back({1'b1, 32'h8000_1000, 32'h8765_4321, 8'h0F, 32'h0, ERR});
    tbl.push_back({1'b0, 32'h8000_0FFC, 32'h0, 8'h00, 32'hFFFF_FFFF, OK});
    tbl.push_back({1'b0, 32'h8000_0000, 32'h0, 8'h00, 32'h0BAD_C0DE, OK});
    tbl.push_back({1'b0, 32'hFFFF_FFFC, 32'h0, 8'h00, 32'h0, ERR});

    repeat (3) @(negedge clk);
    chk("rst_arready", 32'(bus.arready), 32'h0);
    chk("rst_awready", 32'(bus.awready), 32'h0);
    chk("rst_wready",  32'(bus.wready),  32'h0);
    chk("rst_rvalid",  32'(bus.rvalid),  32'h0);
    chk("rst_bvalid",  32'(bus.bvalid),  32'h0);
    chk("rst_rdata",   bus.rdata,        32'h0);
    chk("rst_rresp",   32'(bus.rresp),   32'h0);
    chk("rst_bresp",   32'(bus.bresp),   32'h0);
    rst = 1'b1;
    #1;
    chk("rel_arready_pre", 32'(bus.arready), 32'h0);
    @(negedge clk);
    chk("rel_arready", 32'(bus.arready), 32'h1);
    chk("rel_awready", 32'(bus.awready), 32'h1);

    foreach (tbl[i]) begin
      if (tbl[i].wr)
        wr(tbl[i].addr, tbl[i].data,
           tbl[i].strb, tbl[i].resp);
      else
        rd(tbl[i].addr, tbl[i].exp,
           tbl[i].resp);
      @(negedge clk);
    end

    // write and read requested together
    bus.arvalid = 1'b1;
    bus.araddr  = 32'h8000_0010;
    bus.awvalid = 1'b1;
    bus.awaddr  = 32'h8000_0010;
    bus.wvalid  = 1'b1;
    bus.wdata   = 32'h1357_9BDF;
    bus.wstrb   = 8'h0F;
    bus.bready  = 1'b1;
    bus.rready  = 1'b1;
    wait_acc(1'b1, "sim_wr_accept");
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    #1;
    chk("sim_ar_blocked", 32'(bus.arready), 32'h0);
    wait_rsp(1'b1, lat);
    if (!bus.bvalid) tmo("sim_bvalid");
    chk("sim_wr_first", 32'(bus.rvalid), 32'h0);
    chk("sim_ar_in_b", 32'(bus.arready), 32'h0);
    @(negedge clk);
    #1;
    chk("sim_ar_idle", 32'(bus.arready), 32'h1);
    @(negedge clk);
    bus.arvalid = 1'b0;
    wait_rsp(1'b0, lat);
    if (!bus.rvalid) tmo("sim_rvalid");
    chk("sim_rd_lat", 32'(lat), 32'(RD_LAT));
    chk("sim_rdata", bus.rdata, 32'h1357_9BDF);
    @(negedge clk);
    bus.rready = 1'b0;
    bus.bready = 1'b0;
    @(negedge clk);

    // read response held under backpressure
    bus.arvalid = 1'b1;
    bus.araddr  = 32'h8000_0010;
    wait_acc(1'b0, "bp_accept");
    @(negedge clk);
    bus.arvalid = 1'b0;
    wait_rsp(1'b0, lat);
    if (!bus.rvalid) tmo("bp_rvalid");
    held = bus.rdata;
    chk("bp_rdata", held, 32'h1357_9BDF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rvalid_hold", 32'(bus.rvalid), 32'h1);
      chk("bp_rdata_hold", bus.rdata, held);
      chk("bp_arready", 32'(bus.arready), 32'h0);
    end
    bus.rready = 1'b1;
    @(negedge clk);
    chk("bp_rvalid_drop", 32'(bus.rvalid), 32'h0);
    chk("bp_idle", 32'(bus.arready), 32'h1);
    bus.rready = 1'b0;
    @(negedge clk);

    // reset while a write waits to commit
    wr(32'h8000_0020, 32'h1111_1111, 8'h0F, OK);
    @(negedge clk);
    bus.awvalid = 1'b1;
    bus.awaddr  = 32'h8000_0020;
    bus.wvalid  = 1'b1;
    bus.wdata   = 32'h2222_2222;
    bus.wstrb   = 8'h0F;
    wait_acc(1'b1, "rw_accept");
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b1;
    rst = 1'b0;
    #1;
    chk("rw_bvalid", 32'(bus.bvalid), 32'h0);
    chk("rw_awready", 32'(bus.awready), 32'h0);
    repeat (2) @(negedge clk);
    chk("rw_bvalid_held", 32'(bus.bvalid), 32'h0);
    rst = 1'b1;
    bus.bready = 1'b0;
    @(negedge clk);
    rd(32'h8000_0020, 32'h1111_1111, OK);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dsram_axi_slave.md
DSRAM_AXI_SLAVE -- requirements
Module: dsram_axi_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8000_0000, first byte address served.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit storage words.
REQ-003 SHALL have parameter RD_LAT, default 2, cycles from AR accept to RVALID (range 1..15).
REQ-004 SHALL have parameter WR_LAT, default 2, cycles from AW/W accept to BVALID (range 1..15).
REQ-005 SHALL have ports: clk in 1 system clock; rst in 1, asynchronous, active-low reset (asserted when 0).
REQ-006 SHALL have ports: arvalid in 1; arready out 1; araddr in 32 read byte address.
REQ-007 SHALL have ports: rvalid out 1; rready in 1; rdata out 32 aligned word; rresp out 2.
REQ-008 SHALL have ports: awvalid in 1; awready out 1; awaddr in 32 write byte address.
REQ-009 SHALL have ports: wvalid in 1; wready out 1; wdata in 32; wstrb in 8 (bits 3:0 used, 7:4 ignored).
REQ-010 SHALL have ports: bvalid out 1; bready in 1; bresp out 2.

Function
REQ-011 SHALL use FSM states IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP; one transaction in flight at a time.
REQ-012 In IDLE, arready SHALL be 1; awready and wready SHALL both be 1; all other states drive them 0.
REQ-013 Write accept SHALL require awvalid and wvalid high in the same IDLE cycle; either alone SHALL NOT be accepted.
REQ-014 Read accept SHALL occur on arvalid in IDLE when the write-accept condition is false; a simultaneous write request SHALL take priority.
REQ-015 On accept, address SHALL be latched; latency counter loaded with RD_LAT-1 or WR_LAT-1; next state RD_WAIT/WR_WAIT.
REQ-016 In *_WAIT, counter SHALL decrement each cycle; at 0 move to *_RESP next cycle; total accept-to-valid delay equals RD_LAT/WR_LAT cycles.
REQ-017 Word index SHALL be (addr - BASE_ADDR) >> 2; address bits [1:0] ignored; rdata is the full aligned word (byte extraction is the requester's job).
REQ-018 Address in range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS (computed without 32-bit wrap).
REQ-019 Write SHALL update byte lane i of the word only where wstrb[i]=1, committed in the cycle entering WR_RESP; no update for out-of-range.
REQ-020 Read data SHALL be sampled from storage on the cycle entering RD_RESP and held stable while rvalid=1.
REQ-021 rresp/bresp SHALL be 2'b00 (OKAY) in range, 2'b10 (SLVERR) out of range; out-of-range rdata = 32'h0.
REQ-022 rvalid/bvalid SHALL stay 1 until rready/bready sampled 1; on that cycle return to IDLE, valid drops next cycle.
REQ-023 New accept SHALL NOT occur in the same cycle a response handshake completes (one idle bubble minimum).
REQ-024 wstrb = 4'b0000 with in-range address SHALL complete with OKAY and no storage change.
REQ-025 Storage contents SHALL be unspecified after power-up; not cleared by reset.

Reset
REQ-026 rst=0 SHALL asynchronously force state IDLE, counter 0, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0.
REQ-027 While rst=0, arready/awready/wready SHALL be 0; asserted 1 from first clk edge after rst release.
REQ-028 Reset mid-transaction SHALL abandon it; a pending write not yet committed SHALL NOT modify storage.

Structure
REQ-029 FSM state encodings and RESP_OKAY/RESP_SLVERR constants SHALL live in the shared defines file with the other bus widths.
REQ-030 Storage SHALL be one sub-module dsram_bank (byte-lane write-enabled, synchronous read/write word array); FSM, counter and decode stay in the top.

Verification
REQ-031 Read: preload word 0x8000_0010 = 32'hDEAD_BEEF; arvalid, araddr=0x8000_0012 -> rvalid exactly 2 cycles after accept, rdata=32'hDEAD_BEEF, rresp=00.
REQ-032 Byte write: word=32'h1122_3344; awaddr=wdata address 0x8000_0010, wdata=32'hAA00_0000, wstrb=8'b1000 -> bresp=00; readback 32'hAA22_3344.
REQ-033 Simultaneous: arvalid, awvalid, wvalid all high in IDLE -> write accepted first, arready=0 until IDLE again, then read accepted.
REQ-034 Out of range: araddr=0x8000_1000 (DEPTH 1024) -> rresp=10, rdata=0; awaddr=0x7FFF_FFFC -> bresp=10, storage unchanged.
REQ-035 Backpressure: hold rready=0 for 5 cycles -> rvalid and rdata stable, arready=0; release -> IDLE next cycle.
REQ-036 Reset mid-write: assert rst=0 during WR_WAIT -> bvalid=0 immediately; readback of target word shows old value.
